// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings, width constants and helpers for the memory arbiter
package mem_arbiter_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] OWN_IF = 2'd0;
    localparam logic [1:0] OWN_LD = 2'd1;
    localparam logic [1:0] OWN_ST = 2'd2;
    localparam logic [2:0] W_BYTE = 3'd1;
    localparam logic [2:0] W_HALF = 3'd2;
    localparam logic [2:0] W_WORD = 3'd4;
    localparam int STARVE_LIMIT_DEF = 8;
    typedef struct packed {
        logic        wr;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mc_req_t;
    // zero-extends the low bytes of a load word; widths above a word pass the full word
    function automatic logic [31:0] width_mask(input logic [2:0] width, input logic [31:0] data);
        return width == 3'd0 ? 32'd0 :
               width == W_BYTE ? {24'd0, data[7:0]} :
               width == W_HALF ? {16'd0, data[15:0]} :
               width == 3'd3 ? {8'd0, data[23:0]} : data;
    endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: fixed-priority one-hot picker (st > ld > if) with starvation override for ifetch
module mem_arb_pick (
    input  logic       if_req,
    input  logic       ld_req,
    input  logic       st_req,
    input  logic       starve,
    output logic [2:0] gnt
);
    // bit index of gnt equals the owner code
    always_comb begin
        gnt = (starve && if_req) ? 3'b001 :
              st_req ? 3'b100 :
              ld_req ? 3'b010 :
              if_req ? 3'b001 : 3'b000;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter of ifetch/load/store onto a byte-serial memory controller
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_width,
    output logic        ld_gnt,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [2:0]  st_width,
    input  logic [31:0] st_data,
    output logic        st_gnt,
    output logic        st_done,
    output logic        mc_valid,
    output logic        mc_wr,
    output logic [2:0]  mc_width,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    input  logic        mc_ready,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 2);

    logic [1:0]    state;
    logic [1:0]    owner;
    logic          drop;
    logic [CW-1:0] starve_cnt;
    logic [2:0]    pick;
    logic [1:0]    pick_own;
    logic          starve;
    logic          kill;
    mc_req_t       req_sel;

    assign starve = starve_cnt == CW'(STARVE_LIMIT);
    assign kill   = flush_in && owner != OWN_ST;

    mem_arb_pick u_pick (
        .if_req (if_req),
        .ld_req (ld_req),
        .st_req (st_req),
        .starve (starve),
        .gnt    (pick)
    );

    // winner's request fields as they will be presented to the controller
    always_comb begin
        pick_own = pick[2] ? OWN_ST : pick[1] ? OWN_LD : OWN_IF;
        req_sel  = pick[2] ? {1'b1, st_width, st_addr, st_data} :
                   pick[1] ? {1'b0, ld_width, ld_addr, 32'd0} :
                             {1'b0, W_WORD, if_addr, 32'd0};
    end

    // transaction FSM: grant in IDLE, hold request until accepted, report completion to owner
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            owner    <= OWN_ST;
            drop     <= 1'b0;
            if_gnt   <= 1'b0;
            ld_gnt   <= 1'b0;
            st_gnt   <= 1'b0;
            if_done  <= 1'b0;
            ld_done  <= 1'b0;
            st_done  <= 1'b0;
            if_data  <= 32'd0;
            ld_data  <= 32'd0;
            mc_valid <= 1'b0;
            mc_wr    <= 1'b0;
            mc_width <= 3'd0;
            mc_addr  <= 32'd0;
            mc_wdata <= 32'd0;
        end else if (rdy_in) begin
            {st_gnt, ld_gnt, if_gnt}    <= 3'b000;
            {st_done, ld_done, if_done} <= 3'b000;
            case (state)
                S_IDLE: begin
                    drop <= 1'b0;
                    if (|pick) begin
                        {mc_wr, mc_width, mc_addr, mc_wdata} <= req_sel;
                        mc_valid                    <= 1'b1;
                        {st_gnt, ld_gnt, if_gnt}    <= pick;
                        owner                       <= pick_own;
                        state                       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (kill) drop <= 1'b1;
                    if (mc_ready) begin
                        mc_valid <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (kill) drop <= 1'b1;
                    if (mc_done) begin
                        state <= S_IDLE;
                        drop  <= 1'b0;
                        if (!drop && !kill) begin
                            if_done <= owner == OWN_IF;
                            ld_done <= owner == OWN_LD;
                            st_done <= owner == OWN_ST;
                            if_data <= owner == OWN_IF ? mc_rdata : if_data;
                            ld_data <= owner == OWN_LD ? width_mask(mc_width, mc_rdata) : ld_data;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ifetch starvation counter, advanced only by IDLE decisions that pass ifetch over
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) starve_cnt <= '0;
        else if (rdy_in)
            starve_cnt <= (flush_in || !if_req || (state == S_IDLE && pick[0])) ? '0 :
                          (state == S_IDLE && !starve) ? starve_cnt + 1'b1 : starve_cnt;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with an inline controller model for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
    logic        if_req = 1'b0, ld_req = 1'b0, st_req = 1'b0;
    logic [31:0] if_addr = '0, ld_addr = '0, st_addr = '0, st_data = '0;
    logic [2:0]  ld_width = '0, st_width = '0;
    logic        if_gnt, if_done, ld_gnt, ld_done, st_gnt, st_done;
    logic [31:0] if_data, ld_data;
    logic        mc_valid, mc_wr;
    logic [2:0]  mc_width;
    logic [31:0] mc_addr, mc_wdata;
    logic        mc_ready = 1'b0, mc_done = 1'b0;
    logic [31:0] mc_rdata = '0;

    mem_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_width(ld_width), .ld_gnt(ld_gnt), .ld_done(ld_done),
        .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_width(st_width), .st_data(st_data), .st_gnt(st_gnt),
        .st_done(st_done),
        .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_width(mc_width), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_ready(mc_ready), .mc_done(mc_done), .mc_rdata(mc_rdata)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [1:0] own; logic [31:0] data; } exp_t;
    exp_t        exp_q[$];
    logic [1:0]  gnt_q[$];
    int          compared = 0, mismatched = 0;
    int          ready_delay = 0, done_delay = 1, cph = 0, cc = 0, txn_done = 0;
    logic [67:0] snap = '0;
    logic [2:0]  pd = '0, pg = '0;
    bit          hold_reqs = 1'b0;

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        return a == 32'h100 ? 32'hDEADBEEF : a == 32'h200 ? 32'h12345680 : {a[15:0], ~a[15:0]};
    endfunction

    function automatic exp_t mk(input logic [1:0] own, input logic [31:0] data);
        exp_t e;
        e.own = own;
        e.data = data;
        return e;
    endfunction

    task automatic tick();
        logic [2:0] dn, gn;
        logic [31:0] got;
        exp_t e;
        @(posedge clk_in);
        #2;
        dn = {st_done, ld_done, if_done};
        gn = {st_gnt, ld_gnt, if_gnt};
        for (int k = 0; k < 3; k++) begin
            if (gn[k] && !pg[k]) gnt_q.push_back(2'(k));
            if (dn[k] && !pd[k]) begin
                got = k == 0 ? if_data : ld_data;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL done_unexpected owner=%0d data=%h", k, got);
                end else begin
                    e = exp_q.pop_front();
                    if (e.own !== 2'(k) || (k != 2 && got !== e.data)) begin
                        mismatched++;
                        $display("FAIL done owner=%0d data=%h want owner=%0d data=%h", k, got, e.own, e.data);
                    end
                end
            end
        end
        pd = dn;
        pg = gn;
        mc_done = 1'b0;
        if (rst_in) begin
            cph = 0;
            mc_ready = 1'b0;
        end else begin
            if (cph == 0 && mc_valid) begin
                snap = {mc_wr, mc_width, mc_addr, mc_wdata};
                cc = 0;
                cph = 1;
            end
            if (cph == 1) begin
                if (!mc_valid) begin
                    mc_ready = 1'b0;
                    cph = 2;
                    cc = 0;
                end else begin
                    compared++;
                    if ({mc_wr, mc_width, mc_addr, mc_wdata} !== snap) begin
                        mismatched++;
                        $display("FAIL mc_stable got %h want %h", {mc_wr, mc_width, mc_addr, mc_wdata}, snap);
                    end
                    if (cc >= ready_delay) mc_ready = 1'b1;
                    cc++;
                end
            end else if (cph == 2) begin
                cc++;
                if (cc >= done_delay) begin
                    mc_done = 1'b1;
                    mc_rdata = model_rdata(snap[63:32]);
                    cph = 0;
                    txn_done++;
                end
            end
        end
        if (hold_reqs) begin
            if (if_gnt) {if_req, ld_req, st_req} = 3'b000;
        end else begin
            if (if_gnt) if_req = 1'b0;
            if (ld_gnt) ld_req = 1'b0;
            if (st_gnt) st_req = 1'b0;
        end
    endtask

    task automatic drain(input int n, input int budget);
        int b = 0;
        while ((txn_done < n || exp_q.size() != 0 || cph != 0) && b < budget) begin
            tick();
            b++;
        end
        tick();
        tick();
        compared++;
        if (b >= budget) begin
            mismatched++;
            $display("FAIL drain_timeout txn=%0d want %0d pending=%0d", txn_done, n, exp_q.size());
        end
    endtask

    task automatic wait_phase(input int ph, input string name);
        int b = 0;
        while (cph != ph && b < 40) begin
            tick();
            b++;
        end
        if (b >= 40) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout phase=%0d want %0d", name, cph, ph);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        compared++;
        if ({if_gnt, if_done, ld_gnt, ld_done, st_gnt, st_done, mc_valid, mc_wr, mc_width, mc_addr,
             mc_wdata, if_data, ld_data} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs valid=%b addr=%h if_data=%h ld_data=%h want all 0",
                     mc_valid, mc_addr, if_data, ld_data);
        end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_ld_then_if();
        int n = txn_done + 2;
        gnt_q.delete();
        ld_addr = 32'h100;
        ld_width = W_WORD;
        if_addr = 32'h80;
        ld_req = 1'b1;
        if_req = 1'b1;
        exp_q.push_back(mk(OWN_LD, 32'hDEADBEEF));
        exp_q.push_back(mk(OWN_IF, model_rdata(32'h80)));
        tick();
        compared++;
        if ({ld_gnt, if_gnt, mc_valid, mc_wr, mc_addr} !== {3'b101, 1'b0, 32'h100}) begin
            mismatched++;
            $display("FAIL ld_first_grant got gnt=%b%b valid=%b addr=%h want 1 0 1 00000100",
                     ld_gnt, if_gnt, mc_valid, mc_addr);
        end
        drain(n, 100);
        compared++;
        if (gnt_q.size() != 2 || gnt_q[0] !== OWN_LD || gnt_q[1] !== OWN_IF) begin
            mismatched++;
            $display("FAIL ld_if_order got n=%0d want LD then IF", gnt_q.size());
        end
    endtask

    task automatic test_starvation();
        int n = txn_done + 9;
        gnt_q.delete();
        hold_reqs = 1'b1;
        st_addr = 32'h300;
        st_width = W_WORD;
        st_data = 32'h0BADF00D;
        ld_addr = 32'h100;
        ld_width = W_WORD;
        if_addr = 32'h44;
        {st_req, ld_req, if_req} = 3'b111;
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(OWN_ST, 32'd0));
        exp_q.push_back(mk(OWN_IF, model_rdata(32'h44)));
        drain(n, 400);
        hold_reqs = 1'b0;
        for (int i = 0; i < 9; i++) begin
            compared++;
            if (i >= gnt_q.size() || gnt_q[i] !== (i < 8 ? OWN_ST : OWN_IF)) begin
                mismatched++;
                $display("FAIL starve_order idx=%0d got %0d want %0d", i,
                         i < gnt_q.size() ? gnt_q[i] : 2'd3, i < 8 ? OWN_ST : OWN_IF);
            end
        end
        compared++;
        if (dut.starve_cnt !== '0) begin
            mismatched++;
            $display("FAIL starve_clear got %0d want 0", dut.starve_cnt);
        end
    endtask

    task automatic test_load_widths();
        logic [2:0]  w[5] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4};
        logic [31:0] x[5] = '{32'h00000080, 32'h0, 32'h00005680, 32'h00345680, 32'h12345680};
        for (int i = 0; i < 5; i++) begin
            int n = txn_done + 1;
            ld_addr = 32'h200;
            ld_width = w[i];
            ld_req = 1'b1;
            exp_q.push_back(mk(OWN_LD, x[i]));
            drain(n, 100);
        end
    endtask

    task automatic test_flush_if();
        int n = txn_done + 1;
        done_delay = 4;
        if_addr = 32'h40;
        if_req = 1'b1;
        wait_phase(2, "flush_if_wait");
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        drain(n, 100);
        compared++;
        if (dut.state !== S_IDLE || if_data !== model_rdata(32'h44)) begin
            mismatched++;
            $display("FAIL flush_if got state=%0d if_data=%h want 0 %h", dut.state, if_data, model_rdata(32'h44));
        end
        done_delay = 1;
    endtask

    task automatic test_flush_ld_at_done();
        int b = 0;
        int n = txn_done + 1;
        done_delay = 2;
        ld_addr = 32'h240;
        ld_width = W_WORD;
        ld_req = 1'b1;
        while (!mc_done && b < 40) begin
            tick();
            b++;
        end
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        drain(n, 100);
        compared++;
        if (ld_data !== 32'h12345680) begin
            mismatched++;
            $display("FAIL flush_ld_hold got %h want 12345680", ld_data);
        end
        done_delay = 1;
    endtask

    task automatic test_flush_store();
        int n = txn_done + 1;
        ready_delay = 2;
        st_addr = 32'h500;
        st_width = W_WORD;
        st_data = 32'hA5A5A5A5;
        st_req = 1'b1;
        exp_q.push_back(mk(OWN_ST, 32'd0));
        tick();
        compared++;
        if ({mc_valid, mc_wr, mc_wdata} !== {2'b11, 32'hA5A5A5A5}) begin
            mismatched++;
            $display("FAIL store_fields got valid=%b wr=%b wdata=%h want 1 1 a5a5a5a5", mc_valid, mc_wr, mc_wdata);
        end
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        drain(n, 100);
        ready_delay = 0;
    endtask

    task automatic test_back_to_back_stall();
        int n = txn_done + 1;
        gnt_q.delete();
        ready_delay = 5;
        done_delay = 6;
        ld_addr = 32'h600;
        ld_width = W_HALF;
        ld_req = 1'b1;
        exp_q.push_back(mk(OWN_LD, 32'h0000F9FF));
        wait_phase(2, "stall_wait");
        tick();
        rdy_in = 1'b0;
        repeat (3) tick();
        rdy_in = 1'b1;
        drain(n, 100);
        compared++;
        if (gnt_q.size() != 1) begin
            mismatched++;
            $display("FAIL stall_gnt_count got %0d want 1", gnt_q.size());
        end
        ready_delay = 0;
        done_delay = 1;
    endtask

    task automatic test_async_reset();
        int b = 0;
        ready_delay = 3;
        ld_addr = 32'h700;
        ld_width = W_WORD;
        ld_req = 1'b1;
        while (!mc_valid && b < 20) begin
            tick();
            b++;
        end
        rst_in = 1'b1;
        #1;
        compared++;
        if ({mc_valid, mc_addr, ld_gnt, ld_done} !== '0) begin
            mismatched++;
            $display("FAIL async_reset got valid=%b addr=%h want 0 00000000", mc_valid, mc_addr);
        end
        tick();
        tick();
        rst_in = 1'b0;
        ld_req = 1'b0;
        repeat (6) tick();
        compared++;
        if (mc_valid !== 1'b0 || cph != 0) begin
            mismatched++;
            $display("FAIL post_reset_idle got valid=%b phase=%0d want 0 0", mc_valid, cph);
        end
        ready_delay = 0;
    endtask

    initial begin
        test_reset();
        test_ld_then_if();
        test_starvation();
        test_load_widths();
        test_flush_if();
        test_flush_ld_at_done();
        test_flush_store();
        test_back_to_back_stall();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, meaning consecutive ungranted if_req cycles before ifetch is promoted to top priority.
REQ-002 One clock; reset is asynchronous and active-high; ports named clk_in and rst_in.
REQ-003 clk_in  in  1  clock.
REQ-004 rst_in  in  1  asynchronous active-high reset.
REQ-005 rdy_in  in  1  global enable; low freezes every register.
REQ-006 flush_in  in  1  pipeline flush; cancels ifetch and load responses.
REQ-007 if_req/if_addr  in  1/32  instruction fetch request, always width 4.
REQ-008 if_gnt/if_done/if_data  out  1/1/32  grant pulse, completion pulse, fetched word.
REQ-009 ld_req/ld_addr/ld_width  in  1/32/3  load request; width 1, 2 or 4 bytes.
REQ-010 ld_gnt/ld_done/ld_data  out  1/1/32  grant pulse, completion pulse, zero-extended load data.
REQ-011 st_req/st_addr/st_width/st_data  in  1/32/3/32  store request.
REQ-012 st_gnt/st_done  out  1/1  grant pulse, completion pulse.
REQ-013 mc_valid/mc_wr/mc_width/mc_addr/mc_wdata  out  1/1/3/32/32  request to the byte-serial memory controller.
REQ-014 mc_ready/mc_done/mc_rdata  in  1/1/32  controller accept, completion pulse, load data.

Function
REQ-015 States: IDLE, ISSUE, WAIT; a single transaction is outstanding at any time.
REQ-016 IDLE: if any request is asserted, register the winner into mc_*, set mc_valid=1, pulse the winner's gnt for 1 cycle, record the owner, and go to ISSUE on the same edge.
REQ-017 Priority: st > ld > if, except that if is top when starve_cnt == STARVE_LIMIT.
REQ-018 starve_cnt increments when if_req=1 and if is not granted in an IDLE decision cycle; it saturates at STARVE_LIMIT.
REQ-019 starve_cnt clears on if_gnt, on if_req=0, or on flush_in.
REQ-020 Requesters hold req and fields stable until gnt; the arbiter samples them only in IDLE.
REQ-021 ISSUE: hold mc_valid and fields until mc_ready=1, then set mc_valid=0 and go to WAIT; mc_valid never drops before acceptance.
REQ-022 WAIT: on mc_done, pulse the owner's done for 1 cycle on the next edge, then go to IDLE.
REQ-023 Load data in WAIT: ld_data = mc_rdata masked to ld width (1 -> [7:0], 2 -> [15:0], 4 -> all); if_data = mc_rdata.
REQ-024 Done data outputs hold their value until the next done; done pulses are never back-to-back for the same owner.
REQ-025 Latency: req in IDLE -> mc_valid 1 cycle; mc_done -> owner done 1 cycle; minimum 1 IDLE cycle between transactions.
REQ-026 flush_in in ISSUE or WAIT with owner if or ld: set drop=1; the transaction still completes downstream, but no done pulses.
REQ-027 flush_in with owner st: no effect on the transaction; st_done still pulses.
REQ-028 flush_in in the same cycle as mc_done: done is suppressed for if/ld.
REQ-029 flush_in in IDLE: the grant decision proceeds unchanged, and requesters drop req themselves.
REQ-030 drop clears on return to IDLE.
REQ-031 Width 0 or 3: store is forwarded unchanged; load data is masked to 0 for width 0 and to [23:0] for width 3.
REQ-032 rdy_in=0: all registers hold, including state, pulses, counter and mc_* outputs; no handshake is sampled.

Reset
REQ-033 On rst_in=1, immediately and asynchronously: state=IDLE, all gnt/done outputs 0, mc_valid=0, mc_wr=0, mc_width=0, mc_addr=0, mc_wdata=0, if_data=ld_data=0, starve_cnt=0, drop=0, owner=st.
REQ-034 Reset mid-transaction abandons it with no done; the downstream controller is reset by the same rst_in.

Structure
REQ-035 Shared package: state encoding (IDLE/ISSUE/WAIT), owner encoding (OWN_IF/OWN_LD/OWN_ST), width constants (W_BYTE=1, W_HALF=2, W_WORD=4), and the STARVE_LIMIT default.
REQ-036 One combinational sub-module, mem_arb_pick: inputs are the three reqs and the starve flag; outputs are a one-hot grant.

Verification
REQ-037 Scenario 1: ld_req and if_req both high at cycle 0, ld_addr=0x100, width=4; controller returns 0xDEADBEEF -> ld_gnt at cycle 1, ld_done with ld_data=0xDEADBEEF, then if_gnt.
REQ-038 Scenario 2: st, ld and if asserted continuously, STARVE_LIMIT=8 -> if_gnt no later than the 9th IDLE decision; starve_cnt is 0 afterward.
REQ-039 Scenario 3: load width=1, mc_rdata=0x12345680 -> ld_data=0x00000080.
REQ-040 Scenario 4: flush_in during WAIT of an ifetch -> mc transaction completes, no if_done, state returns to IDLE.
REQ-041 Scenario 5: flush_in during a store, st_data=0xA5A5A5A5 -> mc_wdata=0xA5A5A5A5 and st_done pulses.
REQ-042 Scenario 6: mc_ready held low for 5 cycles, plus rdy_in low for 3 cycles mid-WAIT -> mc_valid and fields stable throughout, exactly one done, no duplicate gnt.
